// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: entry layout, sizing and select encoding.
// The entry ageing helper is shared by the scoreboard shift and the next-cycle match view.
package hazard_scoreboard_pkg;

  localparam int NSRC      = 2;
  localparam int RADDR_W   = 5;
  localparam int DEPTH     = 3;
  localparam int LAT_W     = 2;
  localparam int BJ_STAGE  = 2;
  localparam int FLUSH_STG = 2;
  localparam int SEL_W     = $clog2(DEPTH + 1);

  localparam logic [SEL_W-1:0] SEL_RF = {SEL_W{1'b0}};

  typedef struct packed {
    logic               vld;
    logic [RADDR_W-1:0] rd;
    logic [LAT_W-1:0]   cnt;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rd: {RADDR_W{1'b0}}, cnt: {LAT_W{1'b0}}};

  // One pipeline step: remaining latency counts down and sticks at zero.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r     = e;
    r.cnt = (e.cnt != {LAT_W{1'b0}}) ? (e.cnt - LAT_W'(1)) : e.cnt;
    return r;
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Matches one source operand against every tracked writer and reports the youngest hit.
// sel is the hit stage only when its result is already forwardable, otherwise the regfile.
module hazard_fwd_match
  import hazard_scoreboard_pkg::*;
(
  input  sb_entry_t [DEPTH:1] ent_i,
  input  logic [RADDR_W-1:0]  src_i,
  input  logic                used_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic                hit_o,
  output logic                pending_o
);

  logic [DEPTH:1]   match_s;
  logic [SEL_W-1:0] stage_s;

  // Scan oldest to youngest so the smallest matching stage wins.
  always_comb begin
    hit_o     = 1'b0;
    pending_o = 1'b0;
    stage_s   = SEL_RF;
    match_s   = {DEPTH{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      match_s[k] = used_i && (src_i != {RADDR_W{1'b0}}) && ent_i[k].vld && (ent_i[k].rd == src_i);
      hit_o      = match_s[k] ? 1'b1 : hit_o;
      pending_o  = match_s[k] ? (ent_i[k].cnt != {LAT_W{1'b0}}) : pending_o;
      stage_s    = match_s[k] ? SEL_W'(k) : stage_s;
    end
    sel_o = (hit_o && !pending_o) ? stage_s : SEL_RF;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shifting register-writer scoreboard: operand forward selects for EX and ID-branch consumers,
// plus PC/IF-ID write enables, ID bubble and fetch enable with flush > back-end > fetch > stall priority.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    id_valid,
  input  logic [NSRC*RADDR_W-1:0] id_src,
  input  logic [NSRC-1:0]         id_src_used,
  input  logic                    id_bj,
  input  logic                    id_rfwr,
  input  logic [RADDR_W-1:0]      id_rd,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    id_hilo_use,
  input  logic                    md_busy,
  input  logic                    icache_ok,
  input  logic                    be_stall,
  input  logic                    flush,
  output logic [NSRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [NSRC*SEL_W-1:0]   id_fwd_sel,
  output logic                    pc_wr,
  output logic                    if_id_wr,
  output logic                    id_bubble,
  output logic                    inst_req_en,
  output logic [7:0]              stall_run
);

  sb_entry_t [DEPTH:1]     ent_q, ent_d, aged_s;
  logic [NSRC*SEL_W-1:0]   id_sel_s, ex_sel_s, ex_fwd_sel_q, ex_fwd_sel_d;
  logic [NSRC-1:0]         id_hit_s, id_pend_s, op_stall_s, ex_hit_s, ex_pend_s;
  logic [2*NSRC-1:0]       ex_unused_s;
  logic                    dstall_s, md_stall_s, any_stall_s;
  logic                    pc_wr_s, if_id_wr_s, bubble_s, inst_req_en_s;
  logic [7:0]              stall_run_q, stall_run_d;

  // Positions each entry will hold after the next edge, with latency already counted down.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      aged_s[k] = sb_age(ent_q[k]);
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    hazard_fwd_match u_id_match (
      .ent_i     (ent_q),
      .src_i     (id_src[i*RADDR_W +: RADDR_W]),
      .used_i    (id_src_used[i]),
      .sel_o     (id_sel_s[i*SEL_W +: SEL_W]),
      .hit_o     (id_hit_s[i]),
      .pending_o (id_pend_s[i])
    );

    hazard_fwd_match u_ex_match (
      .ent_i     (aged_s),
      .src_i     (id_src[i*RADDR_W +: RADDR_W]),
      .used_i    (id_src_used[i]),
      .sel_o     (ex_sel_s[i*SEL_W +: SEL_W]),
      .hit_o     (ex_hit_s[i]),
      .pending_o (ex_pend_s[i])
    );

    // A branch in ID may only take a bypass from a producer that has reached BJ_STAGE.
    assign op_stall_s[i] = id_pend_s[i] ||
                           (id_bj && id_hit_s[i] && (id_sel_s[i*SEL_W +: SEL_W] < SEL_W'(BJ_STAGE)));
  end

  assign ex_unused_s = {ex_hit_s, ex_pend_s};
  assign dstall_s    = |op_stall_s;
  assign md_stall_s  = md_busy && id_hilo_use;
  assign any_stall_s = (dstall_s && id_valid) || md_stall_s;

  // Pipeline enable priority; everything is held off while reset is asserted.
  always_comb begin
    pc_wr_s       = 1'b0;
    if_id_wr_s    = 1'b0;
    inst_req_en_s = 1'b0;
    bubble_s      = 1'b1;
    if (!resetn) begin
      bubble_s = 1'b1;
    end else if (flush) begin
      {pc_wr_s, if_id_wr_s, inst_req_en_s, bubble_s} = 4'b1110;
    end else if (be_stall) begin
      {pc_wr_s, if_id_wr_s, inst_req_en_s, bubble_s} = 4'b0000;
    end else if (!icache_ok || md_stall_s || (dstall_s && id_valid)) begin
      {pc_wr_s, if_id_wr_s, inst_req_en_s, bubble_s} = 4'b0001;
    end else begin
      {pc_wr_s, if_id_wr_s, inst_req_en_s, bubble_s} = 4'b1110;
    end
  end

  // Scoreboard shift; a flush from MEM kills every writer younger than the excepting instruction.
  always_comb begin
    ent_d        = ent_q;
    ex_fwd_sel_d = ex_fwd_sel_q;
    if (flush || !be_stall) begin
      ent_d[1].vld = id_valid && id_rfwr && (id_rd != {RADDR_W{1'b0}}) && !bubble_s && !flush;
      ent_d[1].rd  = id_rd;
      ent_d[1].cnt = id_lat;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k+1]     = aged_s[k];
        ent_d[k+1].vld = aged_s[k].vld && !(flush && (k < FLUSH_STG));
      end
      ex_fwd_sel_d = bubble_s ? {(NSRC*SEL_W){1'b0}} : ex_sel_s;
    end else begin
      ent_d        = ent_q;
      ex_fwd_sel_d = ex_fwd_sel_q;
    end
  end

  assign stall_run_d = any_stall_s ? ((stall_run_q == 8'hFF) ? stall_run_q : (stall_run_q + 8'd1))
                                   : 8'd0;

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_q        <= {DEPTH{SB_EMPTY}};
      ex_fwd_sel_q <= {(NSRC*SEL_W){1'b0}};
      stall_run_q  <= 8'd0;
    end else begin
      ent_q        <= ent_d;
      ex_fwd_sel_q <= ex_fwd_sel_d;
      stall_run_q  <= stall_run_d;
    end
  end

  assign pc_wr       = pc_wr_s;
  assign if_id_wr    = if_id_wr_s;
  assign id_bubble   = bubble_s;
  assign inst_req_en = inst_req_en_s;
  assign id_fwd_sel  = resetn ? id_sel_s : {(NSRC*SEL_W){1'b0}};
  assign ex_fwd_sel  = ex_fwd_sel_q;
  assign stall_run   = stall_run_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid, id_bj, id_rfwr, id_hilo_use, md_busy, icache_ok, be_stall, flush;
  logic [4:0]  src0, src1, id_rd;
  logic [1:0]  id_src_used, id_lat;
  logic [3:0]  ex_fwd_sel, id_fwd_sel;
  logic        pc_wr, if_id_wr, id_bubble, inst_req_en;
  logic [7:0]  stall_run;

  typedef struct {
    string      nm;
    logic [19:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // {pc_wr, if_id_wr, id_bubble, inst_req_en}
  localparam logic [3:0] RUN = 4'b1101;
  localparam logic [3:0] STL = 4'b0010;
  localparam logic [3:0] HLD = 4'b0000;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .resetn      (resetn),
    .id_valid    (id_valid),
    .id_src      ({src1, src0}),
    .id_src_used (id_src_used),
    .id_bj       (id_bj),
    .id_rfwr     (id_rfwr),
    .id_rd       (id_rd),
    .id_lat      (id_lat),
    .id_hilo_use (id_hilo_use),
    .md_busy     (md_busy),
    .icache_ok   (icache_ok),
    .be_stall    (be_stall),
    .flush       (flush),
    .ex_fwd_sel  (ex_fwd_sel),
    .id_fwd_sel  (id_fwd_sel),
    .pc_wr       (pc_wr),
    .if_id_wr    (if_id_wr),
    .id_bubble   (id_bubble),
    .inst_req_en (inst_req_en),
    .stall_run   (stall_run)
  );

  task automatic set_idle();
    id_valid = 1'b0; id_bj = 1'b0; id_rfwr = 1'b0; id_hilo_use = 1'b0;
    md_busy = 1'b0; icache_ok = 1'b1; be_stall = 1'b0; flush = 1'b0;
    src0 = 5'd0; src1 = 5'd0; id_rd = 5'd0; id_src_used = 2'b00; id_lat = 2'd0;
  endtask

  task automatic set_ins(input logic rfwr, input logic [4:0] rd, input logic [1:0] lat,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic bj);
    set_idle();
    id_valid = 1'b1; id_rfwr = rfwr; id_rd = rd; id_lat = lat;
    src0 = s0; src1 = s1; id_src_used = used; id_bj = bj;
  endtask

  // Queue this cycle's expected outputs, then advance to just after the next rising edge.
  task automatic cyc(input string nm, input logic [3:0] ctl, input logic [3:0] ids,
                     input logic [3:0] exs, input logic [7:0] sr);
    exp_t e;
    e.nm = nm;
    e.v  = {ctl, ids, exs, sr};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_wr, if_id_wr, id_bubble, inst_req_en, id_fwd_sel, ex_fwd_sel, stall_run};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got ctl=%b id=%b ex=%b sr=%0d, want ctl=%b id=%b ex=%b sr=%0d",
                 e.nm, act[19:16], act[15:12], act[11:8], act[7:0],
                 e.v[19:16], e.v[15:12], e.v[11:8], e.v[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    set_ins(1'b1, 5'd3, 2'd0, 5'd1, 5'd2, 2'b11, 1'b0);
    cyc("reset0", STL, 4'h0, 4'h0, 8'd0);
    cyc("reset1", STL, 4'h0, 4'h0, 8'd0);
    resetn = 1'b1;

    cyc("alu_r3", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b1, 5'd8, 2'd0, 5'd3, 5'd4, 2'b11, 1'b0);
    cyc("add_use_r3", RUN, 4'b0001, 4'h0, 8'd0);
    set_idle();
    cyc("ex_bypass", RUN, 4'h0, 4'b0001, 8'd0);

    set_ins(1'b1, 5'd5, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("lw_r5", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b1, 5'd9, 2'd0, 5'd5, 5'd8, 2'b11, 1'b0);
    cyc("lw_use_stall", STL, 4'b1100, 4'h0, 8'd0);
    cyc("lw_use_go", RUN, 4'b0010, 4'h0, 8'd1);
    set_idle();
    cyc("mem_bypass", RUN, 4'h0, 4'b0010, 8'd0);

    set_ins(1'b1, 5'd7, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("alu_r7", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b0, 5'd0, 2'd0, 5'd7, 5'd0, 2'b11, 1'b1);
    cyc("beq_stall", STL, 4'b0001, 4'h0, 8'd0);
    cyc("beq_go", RUN, 4'b0010, 4'h0, 8'd1);

    set_ins(1'b1, 5'd4, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("alu_r4_a", RUN, 4'h0, 4'b0010, 8'd0);
    cyc("alu_r4_b", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b1, 5'd10, 2'd0, 5'd4, 5'd4, 2'b11, 1'b0);
    cyc("r4_youngest", RUN, 4'b0101, 4'h0, 8'd0);
    set_idle();
    cyc("r4_ex_sel", RUN, 4'h0, 4'b0101, 8'd0);

    set_ins(1'b1, 5'd6, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("lw_r6", RUN, 4'h0, 4'h0, 8'd0);
    set_idle();
    flush = 1'b1;
    cyc("flush_r6", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b0, 5'd0, 2'd0, 5'd6, 5'd0, 2'b01, 1'b0);
    cyc("r6_after_flush", RUN, 4'h0, 4'h0, 8'd0);

    set_ins(1'b1, 5'd11, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("lw_r11", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b0, 5'd0, 2'd0, 5'd11, 5'd0, 2'b01, 1'b0);
    cyc("r11_stall", STL, 4'h0, 4'h0, 8'd0);
    be_stall = 1'b1;
    cyc("be_hold", HLD, 4'b0010, 4'h0, 8'd1);
    flush = 1'b1;
    cyc("flush_over_be", RUN, 4'b0010, 4'h0, 8'd0);
    set_idle();
    cyc("after_flush_ex", RUN, 4'h0, 4'b0010, 8'd0);
    icache_ok = 1'b0;
    cyc("icache_miss", STL, 4'h0, 4'h0, 8'd0);

    set_idle();
    id_valid = 1'b1; id_hilo_use = 1'b1; md_busy = 1'b1;
    for (int i = 0; i < 258; i++) begin
      cyc("md_stall_run", STL, 4'h0, 4'h0, (i > 255) ? 8'd255 : 8'(i));
    end
    set_idle();
    cyc("sr_sat_hold", RUN, 4'h0, 4'h0, 8'd255);
    cyc("sr_clear", RUN, 4'h0, 4'h0, 8'd0);

    set_ins(1'b1, 5'd12, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0);
    cyc("lw3_r12", RUN, 4'h0, 4'h0, 8'd0);
    set_ins(1'b0, 5'd0, 2'd0, 5'd12, 5'd0, 2'b01, 1'b0);
    cyc("r12_stall", STL, 4'h0, 4'h0, 8'd0);
    resetn = 1'b0;
    cyc("reset_mid_stall", STL, 4'h0, 4'h0, 8'd0);
    resetn = 1'b1;
    cyc("post_reset", RUN, 4'h0, 4'h0, 8'd0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
